// File: rtl/uart_pkg.sv
// Shared constants and state type for the buffered UART transmitter.
// Frame shape is 8N1 with an idle-high line.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam int   STOP_BITS  = 1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push handshake between game logic and the UART transmitter.
// A push happens on a clk edge where tx_valid and tx_ready are both high.
interface uart_tx_fifo_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and a show-ahead read port.
// Push when full and pop when empty are ignored, so count never overflows.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_q];
  assign count   = count_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO front end, FSM-driven serializer.
// RsTx is registered from the current state, one cycle behind it.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_tx_fifo_if.slave               tx_if,
  output logic                        RsTx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [IW-1:0] bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic       pop;
  logic       full, empty;
  logic [7:0] head;
  logic       baud_last;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_if.tx_valid),
    .wdata (tx_if.tx_data),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign tx_if.tx_ready = ~full;
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT-1));
  assign busy = (state_q != IDLE) | ~empty;
  assign RsTx = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == IW'(DATA_BITS-1)) begin
            bit_d   = '0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = bit_q + 1'b1;
          // Chain straight into the next start bit for a gapless stream.
          if (bit_q == IW'(STOP_BITS-1)) begin
            bit_d   = '0;
            state_d = IDLE;
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
              state_d = START;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = IDLE_LEVEL;
    unique case (state_q)
      START:   tx_d = ~IDLE_LEVEL;
      DATA:    tx_d = shift_q[0];
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo at CLKS_PER_BIT=4.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       RsTx;
  logic       busy;
  logic [3:0] fifo_count;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_if      (bus),
    .RsTx       (RsTx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [7:0] eb [16];

  // Line level at offset off after the pop edge of a frame carrying b.
  function automatic logic fbit(int off, logic [7:0] b);
    if (off >= 1 && off <= CPB) return 1'b0;
    if (off > CPB && off <= 9 * CPB) return b[(off - CPB - 1) / CPB];
    return 1'b1;
  endfunction

  // Expected line after edge k for n gapless frames popped from edge 1.
  function automatic logic exp_line(int k, int n);
    int o, m;
    o = k - 1;
    if (o < 1 || o > FRAME * n) return 1'b1;
    m = (o - 1) / FRAME;
    return fbit(o - FRAME * m, eb[m]);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    tick();
    tick();
    total++;
    if (RsTx !== 1'b1) $display("FAIL rst_line got %b want 1", RsTx);
    else passed++;
    total++;
    if (bus.tx_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", bus.tx_ready);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else passed++;
    total++;
    if (fifo_count !== 4'd0) $display("FAIL rst_count got %0d want 0", fifo_count);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single;
    eb[0] = 8'h61;
    bus.tx_data = 8'h61;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    total++;
    if (fifo_count !== 4'd1) $display("FAIL single_cnt0 got %0d want 1", fifo_count);
    else passed++;
    total++;
    if (busy !== 1'b1) $display("FAIL single_busy0 got %b want 1", busy);
    else passed++;
    for (int k = 1; k <= 45; k++) begin
      tick();
      total++;
      if (RsTx !== exp_line(k, 1))
        $display("FAIL single_line edge %0d got %b want %b", k, RsTx, exp_line(k, 1));
      else passed++;
      total++;
      if (busy !== (k <= FRAME))
        $display("FAIL single_busy edge %0d got %b want %b", k, busy, k <= FRAME);
      else passed++;
      if (k == 1) begin
        total++;
        if (fifo_count !== 4'd0) $display("FAIL single_cnt1 got %0d want 0", fifo_count);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back;
    eb[0] = 8'h6B;
    eb[1] = 8'h6C;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h6B;
    tick();
    bus.tx_data = 8'h6C;
    tick();
    bus.tx_valid = 1'b0;
    total++;
    if (fifo_count !== 4'd1) $display("FAIL b2b_cnt got %0d want 1", fifo_count);
    else passed++;
    for (int k = 2; k <= 85; k++) begin
      tick();
      total++;
      if (RsTx !== exp_line(k, 2))
        $display("FAIL b2b_line edge %0d got %b want %b", k, RsTx, exp_line(k, 2));
      else passed++;
      total++;
      if (busy !== (k <= 2 * FRAME))
        $display("FAIL b2b_busy edge %0d got %b want %b", k, busy, k <= 2 * FRAME);
      else passed++;
    end
  endtask

  task automatic test_fill;
    logic acc;
    logic got10;
    got10 = 1'b0;
    for (int i = 0; i < 9; i++) eb[i] = 8'h10 + 8'(i);
    eb[9] = 8'h19;
    for (int k = 0; k <= 405; k++) begin
      if (k <= 8) begin
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'h10 + 8'(k);
        total++;
        if (bus.tx_ready !== 1'b1)
          $display("FAIL fill_ready edge %0d got %b want 1", k, bus.tx_ready);
        else passed++;
      end else if (!got10) begin
        bus.tx_valid = 1'b1;
        bus.tx_data = bus.tx_ready ? 8'h19 : ((k % 2 == 1) ? 8'hA5 : 8'h5A);
      end else begin
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'hFF;
      end
      acc = bus.tx_valid & bus.tx_ready;
      tick();
      if (k > 8 && acc && !got10) begin
        got10 = 1'b1;
        total++;
        if (k != 42) $display("FAIL fill_accept_edge got %0d want 42", k);
        else passed++;
      end
      if (k == 8) begin
        total++;
        if (fifo_count !== 4'd8) $display("FAIL fill_full got %0d want 8", fifo_count);
        else passed++;
        total++;
        if (bus.tx_ready !== 1'b0) $display("FAIL fill_notready got %b want 0", bus.tx_ready);
        else passed++;
      end
      if (k == 41) begin
        total++;
        if (fifo_count !== 4'd7) $display("FAIL fill_pop_cnt got %0d want 7", fifo_count);
        else passed++;
        total++;
        if (bus.tx_ready !== 1'b1) $display("FAIL fill_reready got %b want 1", bus.tx_ready);
        else passed++;
      end
      if (k == 42) begin
        total++;
        if (fifo_count !== 4'd8) $display("FAIL fill_refull got %0d want 8", fifo_count);
        else passed++;
      end
      if (k >= 1) begin
        total++;
        if (RsTx !== exp_line(k, 10))
          $display("FAIL fill_line edge %0d got %b want %b", k, RsTx, exp_line(k, 10));
        else passed++;
      end
    end
    total++;
    if (got10 !== 1'b1) $display("FAIL fill_tenth got %b want 1", got10);
    else passed++;
    total++;
    if (busy !== 1'b0 || fifo_count !== 4'd0)
      $display("FAIL fill_drain got busy=%b cnt=%0d want busy=0 cnt=0", busy, fifo_count);
    else passed++;
  endtask

  task automatic test_simul;
    for (int i = 0; i < 5; i++) eb[i] = 8'hA0 + 8'(i);
    for (int k = 0; k <= 205; k++) begin
      bus.tx_valid = (k <= 3) || (k == 41);
      bus.tx_data = (k <= 3) ? 8'hA0 + 8'(k) : 8'hA4;
      tick();
      if (k == 40 || k == 41) begin
        total++;
        if (fifo_count !== 4'd3)
          $display("FAIL simul_cnt edge %0d got %0d want 3", k, fifo_count);
        else passed++;
      end
      total++;
      if (RsTx !== exp_line(k, 5))
        $display("FAIL simul_line edge %0d got %b want %b", k, RsTx, exp_line(k, 5));
      else passed++;
    end
    bus.tx_valid = 1'b0;
    total++;
    if (busy !== 1'b0) $display("FAIL simul_idle got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_reset_mid;
    eb[0] = 8'hC3;
    for (int k = 0; k <= 17; k++) begin
      bus.tx_valid = (k <= 2);
      bus.tx_data = 8'hC3 + 8'(k);
      tick();
      if (k == 2) begin
        total++;
        if (fifo_count !== 4'd2) $display("FAIL rmid_queued got %0d want 2", fifo_count);
        else passed++;
      end
      total++;
      if (RsTx !== exp_line(k, 1))
        $display("FAIL rmid_line edge %0d got %b want %b", k, RsTx, exp_line(k, 1));
      else passed++;
    end
    reset = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hEE;
    tick();
    reset = 1'b0;
    bus.tx_valid = 1'b0;
    total++;
    if (RsTx !== 1'b1) $display("FAIL rmid_line_rst got %b want 1", RsTx);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy);
    else passed++;
    total++;
    if (fifo_count !== 4'd0) $display("FAIL rmid_cnt got %0d want 0", fifo_count);
    else passed++;
    for (int k = 0; k < 60; k++) begin
      tick();
      total++;
      if (RsTx !== 1'b1 || busy !== 1'b0)
        $display("FAIL rmid_quiet cycle %0d got line=%b busy=%b want 1/0", k, RsTx, busy);
      else passed++;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_simul();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
